// File: rtl/lcd_pkg.sv
// lcd_pkg: shared encodings, opcode masks, DDRAM line bounds and helpers for the HD44780 responder.
package lcd_pkg;
   typedef enum logic [1:0] {S_IDLE, S_EXEC, S_CLEAR} state_t;
   typedef enum logic [3:0] {I_NOP, I_CLR, I_HOME, I_ENTRY, I_DISP, I_SHIFT, I_FUNC, I_CGA, I_DDA} op_t;
   localparam logic [7:0] OP_CLEAR = 8'h01;
   localparam logic [7:0] OP_HOME  = 8'h02;
   localparam logic [7:0] OP_ENTRY = 8'h04;
   localparam logic [7:0] OP_DISP  = 8'h08;
   localparam logic [7:0] OP_SHIFT = 8'h10;
   localparam logic [7:0] OP_FUNC  = 8'h20;
   localparam logic [7:0] OP_CGRAM = 8'h40;
   localparam logic [7:0] OP_DDRAM = 8'h80;
   localparam logic [6:0] L1_END   = 7'h27;
   localparam logic [6:0] L2_START = 7'h40;
   localparam logic [6:0] L2_END   = 7'h67;
   localparam logic [6:0] N1_END   = 7'h4F;
   localparam logic [7:0] BLANK    = 8'h20;

   // Highest set bit of the instruction byte selects the command.
   function automatic op_t decode(input logic [7:0] d);
      return ((d & OP_DDRAM) != 8'h00) ? I_DDA :
             ((d & OP_CGRAM) != 8'h00) ? I_CGA :
             ((d & OP_FUNC)  != 8'h00) ? I_FUNC :
             ((d & OP_SHIFT) != 8'h00) ? I_SHIFT :
             ((d & OP_DISP)  != 8'h00) ? I_DISP :
             ((d & OP_ENTRY) != 8'h00) ? I_ENTRY :
             ((d & OP_HOME)  != 8'h00) ? I_HOME :
             ((d & OP_CLEAR) != 8'h00) ? I_CLR : I_NOP;
   endfunction

   function automatic logic [5:0] shift40(input logic [5:0] s, input logic up);
      return up ? ((s == 6'd39) ? 6'd0 : s + 6'd1) : ((s == 6'd0) ? 6'd39 : s - 6'd1);
   endfunction
endpackage

// File: rtl/lcd_ac_step.sv
// lcd_ac_step: next address-counter value for one increment/decrement in CGRAM or DDRAM space.
module lcd_ac_step
   import lcd_pkg::*;
(
   input  logic [6:0] ac,
   input  logic       inc,
   input  logic       cg_mode,
   input  logic       func_n,
   output logic [6:0] ac_next
);
   // Two-line DDRAM skips the 0x28..0x3F hole; one-line mode wraps at 0x4F.
   always_comb
      ac_next = cg_mode ? {1'b0, (inc ? ac[5:0] + 6'd1 : ac[5:0] - 6'd1)}
              : func_n  ? (inc ? ((ac == L1_END) ? L2_START : (ac == L2_END) ? 7'h00 : ac + 7'd1)
                               : ((ac == 7'h00) ? L2_END : (ac == L2_START) ? L1_END : ac - 7'd1))
              : inc     ? ((ac >= N1_END) ? 7'h00 : ac + 7'd1)
                        : ((ac == 7'h00) ? N1_END : ac - 7'd1);
endmodule

// File: rtl/lcd_hd44780_responder.sv
// lcd_hd44780_responder: panel-side HD44780 bus model with DDRAM/CGRAM, AC, busy timing and
// a registered DDRAM readback port for renderers and checkers.
module lcd_hd44780_responder
   import lcd_pkg::*;
#(
   parameter int BUSY_CYC  = 40,
   parameter int CLEAR_CYC = 160
) (
   input  logic       Clk,
   input  logic       rst,
   input  logic       LCD_EN,
   input  logic       LCD_RS,
   input  logic       LCD_RW,
   input  logic [7:0] lcd_data_in,
   output logic [7:0] lcd_data_out,
   output logic       lcd_data_oe,
   output logic       busy,
   output logic       err,
   output logic       disp_on,
   output logic       cursor_on,
   output logic       blink_on,
   output logic       func_dl,
   output logic       func_n,
   output logic       func_f,
   output logic       entry_id,
   output logic       entry_s,
   output logic [5:0] disp_shift,
   input  logic [6:0] disp_addr,
   output logic [7:0] disp_char
);
   state_t      state, state_nx;
   op_t         op;
   logic        e_q, rs_q, rw_q;
   logic [7:0]  d_q;
   logic [15:0] cnt;
   logic [6:0]  ptr, ac, ac_stepped;
   logic        cg_mode, fall, stat_rd, xfer_ok, ins_wr, dat_wr, dat_rd, step_inc;
   logic [7:0]  ddram [128];
   logic [7:0]  cgram [64];

   assign fall     = e_q & ~LCD_EN;
   assign stat_rd  = ~rs_q & rw_q;
   assign xfer_ok  = fall & ~busy & ~stat_rd;
   assign ins_wr   = xfer_ok & ~rs_q;
   assign dat_wr   = xfer_ok & rs_q & ~rw_q;
   assign dat_rd   = xfer_ok & rs_q & rw_q;
   assign op       = decode(d_q);
   assign busy     = state != S_IDLE;
   assign step_inc = ins_wr ? d_q[2] : entry_id;
   assign lcd_data_oe  = e_q & rw_q;
   assign lcd_data_out = ~lcd_data_oe ? 8'h00 : ~rs_q ? {busy, ac} : cg_mode ? cgram[ac[5:0]] : ddram[ac];

   lcd_ac_step u_step (
      .ac      (ac),
      .inc     (step_inc),
      .cg_mode (cg_mode),
      .func_n  (func_n),
      .ac_next (ac_stepped)
   );

   always_comb begin
      state_nx = state;
      case (state)
         S_IDLE:  state_nx = (ins_wr && op == I_CLR) ? S_CLEAR : xfer_ok ? S_EXEC : S_IDLE;
         S_EXEC:  state_nx = (cnt == 16'd1) ? S_IDLE : S_EXEC;
         S_CLEAR: state_nx = (ptr == 7'h7F) ? S_EXEC : S_CLEAR;
         default: state_nx = S_IDLE;
      endcase
   end

   // cnt is preloaded while idle/clearing so it holds the right budget on entry to EXEC.
   always_ff @(posedge Clk) begin
      if (rst) begin
         state <= S_IDLE;
         cnt   <= 16'd0;
         ptr   <= 7'd0;
      end else begin
         state <= state_nx;
         cnt   <= (state == S_IDLE) ? 16'(BUSY_CYC) : (state == S_CLEAR) ? 16'(CLEAR_CYC - 128) : cnt - 16'd1;
         ptr   <= (state == S_CLEAR) ? ptr + 7'd1 : 7'd0;
      end
   end

   always_ff @(posedge Clk) begin
      if (rst) begin
         {e_q, rs_q, rw_q, d_q} <= '0;
         ac         <= 7'd0;
         cg_mode    <= 1'b0;
         err        <= 1'b0;
         {disp_on, cursor_on, blink_on} <= 3'b000;
         {func_dl, func_n, func_f}      <= 3'b100;
         {entry_id, entry_s}            <= 2'b10;
         disp_shift <= 6'd0;
         disp_char  <= 8'h00;
      end else begin
         {e_q, rs_q, rw_q, d_q} <= {LCD_EN, LCD_RS, LCD_RW, lcd_data_in};
         err       <= fall & busy & ~stat_rd;
         disp_char <= ddram[disp_addr];
         if (ins_wr) begin
            case (op)
               I_CLR:   begin ac <= 7'd0; cg_mode <= 1'b0; entry_id <= 1'b1; disp_shift <= 6'd0; end
               I_HOME:  begin ac <= 7'd0; cg_mode <= 1'b0; disp_shift <= 6'd0; end
               I_ENTRY: {entry_id, entry_s} <= d_q[1:0];
               I_DISP:  {disp_on, cursor_on, blink_on} <= d_q[2:0];
               I_SHIFT: if (d_q[3]) disp_shift <= shift40(disp_shift, d_q[2]); else ac <= ac_stepped;
               I_FUNC:  {func_dl, func_n, func_f} <= d_q[4:2];
               I_CGA:   begin ac <= {1'b0, d_q[5:0]}; cg_mode <= 1'b1; end
               I_DDA:   begin ac <= d_q[6:0]; cg_mode <= 1'b0; end
               default: ;
            endcase
         end else if (dat_wr || dat_rd) begin
            ac <= ac_stepped;
            if (dat_wr && entry_s && !cg_mode) disp_shift <= shift40(disp_shift, entry_id);
         end
      end
   end

   // RAM contents survive reset; the sweep stops writing as soon as rst is seen.
   always_ff @(posedge Clk) begin
      if (!rst) begin
         if (state == S_CLEAR) ddram[ptr] <= BLANK;
         else if (dat_wr && !cg_mode) ddram[ac] <= d_q;
         if (dat_wr && cg_mode) cgram[ac[5:0]] <= d_q;
      end
   end
endmodule

// File: tb/tb_lcd_hd44780_responder.sv
// tb_lcd_hd44780_responder: directed table-driven bench for the HD44780 responder.
module tb_lcd_hd44780_responder;
   logic       Clk = 1'b0, rst = 1'b1;
   logic       LCD_EN = 1'b0, LCD_RS = 1'b0, LCD_RW = 1'b0;
   logic [7:0] lcd_data_in = 8'h00;
   logic [6:0] disp_addr = 7'd0;
   logic [7:0] lcd_data_out, disp_char, flags, q;
   logic       lcd_data_oe, busy, err, last_oe;
   logic       disp_on, cursor_on, blink_on, func_dl, func_n, func_f, entry_id, entry_s;
   logic [5:0] disp_shift;
   int         checks = 0, errors = 0, n = 0, bad = 0;

   typedef enum int {K_WR, K_RD, K_DISP, K_FLG, K_SHF} kind_t;
   typedef struct {
      kind_t      k;
      logic       rs;
      logic [7:0] d;
      logic [7:0] exp;
   } vec_t;
   vec_t tbl[$];

   lcd_hd44780_responder dut (
      .Clk(Clk), .rst(rst), .LCD_EN(LCD_EN), .LCD_RS(LCD_RS), .LCD_RW(LCD_RW),
      .lcd_data_in(lcd_data_in), .lcd_data_out(lcd_data_out), .lcd_data_oe(lcd_data_oe),
      .busy(busy), .err(err), .disp_on(disp_on), .cursor_on(cursor_on), .blink_on(blink_on),
      .func_dl(func_dl), .func_n(func_n), .func_f(func_f), .entry_id(entry_id), .entry_s(entry_s),
      .disp_shift(disp_shift), .disp_addr(disp_addr), .disp_char(disp_char)
   );

   always #5 Clk = ~Clk;
   assign flags = {disp_on, cursor_on, blink_on, func_dl, func_n, func_f, entry_id, entry_s};

   initial begin
      #2_000_000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1);
   end

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s got=%0h want=%0h", name, act, exp);
      end
   endtask

   task automatic xfer(input logic rs, input logic rw, input logic [7:0] d, output logic [7:0] r);
      @(negedge Clk);
      LCD_RS = rs; LCD_RW = rw; lcd_data_in = d; LCD_EN = 1'b1;
      @(negedge Clk);
      @(negedge Clk);
      r = lcd_data_out;
      last_oe = lcd_data_oe;
      LCD_EN = 1'b0;
      @(negedge Clk);
   endtask

   task automatic wait_idle(output int cyc);
      cyc = 0;
      while (busy && cyc < 400) begin
         cyc++;
         @(negedge Clk);
      end
      if (busy) begin
         checks++;
         errors++;
         $display("FAIL idle_timeout got=busy want=idle");
      end
   endtask

   task automatic wr(input logic rs, input logic [7:0] d);
      logic [7:0] r;
      int c;
      xfer(rs, 1'b0, d, r);
      wait_idle(c);
   endtask

   task automatic peek(input logic [6:0] a, output logic [7:0] v);
      disp_addr = a;
      @(negedge Clk);
      v = disp_char;
   endtask

   function automatic void add(kind_t k, logic rs, logic [7:0] d, logic [7:0] exp);
      tbl.push_back('{k, rs, d, exp});
   endfunction

   initial begin
      logic [7:0] pat [8] = '{8'h04, 8'h04, 8'h1F, 8'h04, 8'h04, 8'h00, 8'h1F, 8'h00};
      logic [6:0] pa [5] = '{7'd5, 7'd40, 7'd70, 7'd100, 7'd127};
      logic [7:0] pv [5] = '{8'h58, 8'h58, 8'h41, 8'h42, 8'h43};
      logic [7:0] v;
      add(K_WR, 0, 8'h80, 0); add(K_WR, 1, 8'h4C, 0); add(K_WR, 1, 8'h43, 0); add(K_WR, 1, 8'h44, 0);
      add(K_RD, 0, 8'h00, 8'h03);
      add(K_DISP, 0, 8'h00, 8'h4C); add(K_DISP, 0, 8'h01, 8'h43); add(K_DISP, 0, 8'h02, 8'h44);
      add(K_WR, 0, 8'hA7, 0); add(K_WR, 1, 8'h5A, 0); add(K_RD, 0, 8'h00, 8'h40); add(K_DISP, 0, 8'h27, 8'h5A);
      add(K_WR, 0, 8'h04, 0); add(K_FLG, 0, 0, 8'h18);
      add(K_WR, 0, 8'h80, 0); add(K_WR, 1, 8'h31, 0); add(K_RD, 0, 8'h00, 8'h67); add(K_DISP, 0, 8'h00, 8'h31);
      add(K_WR, 0, 8'h06, 0);
      add(K_WR, 0, 8'h40, 0);
      for (int i = 0; i < 8; i++) add(K_WR, 1, pat[i], 0);
      add(K_RD, 0, 8'h00, 8'h08);
      add(K_WR, 0, 8'h40, 0);
      for (int i = 0; i < 8; i++) add(K_RD, 1, 8'h00, pat[i]);
      add(K_RD, 0, 8'h00, 8'h08);
      add(K_WR, 0, 8'h7F, 0); add(K_WR, 1, 8'hAA, 0); add(K_WR, 1, 8'h55, 0); add(K_RD, 0, 8'h00, 8'h01);
      add(K_DISP, 0, 8'h00, 8'h31);
      add(K_WR, 0, 8'h80, 0);
      add(K_WR, 0, 8'h18, 0); add(K_SHF, 0, 0, 8'd39);
      add(K_WR, 0, 8'h1C, 0); add(K_SHF, 0, 0, 8'd0);
      add(K_WR, 0, 8'h1C, 0); add(K_SHF, 0, 0, 8'd1);
      add(K_WR, 0, 8'h14, 0); add(K_RD, 0, 8'h00, 8'h01);
      add(K_WR, 0, 8'h10, 0); add(K_WR, 0, 8'h10, 0); add(K_RD, 0, 8'h00, 8'h67);
      add(K_WR, 0, 8'h0E, 0); add(K_FLG, 0, 0, 8'hDA);
      add(K_WR, 0, 8'h02, 0); add(K_RD, 0, 8'h00, 8'h00); add(K_SHF, 0, 0, 8'd0);
      add(K_WR, 0, 8'h07, 0); add(K_WR, 1, 8'h41, 0); add(K_SHF, 0, 0, 8'd1); add(K_RD, 0, 8'h00, 8'h01);
      add(K_WR, 0, 8'h06, 0);
      add(K_WR, 0, 8'h30, 0); add(K_WR, 0, 8'hCF, 0); add(K_WR, 1, 8'h42, 0); add(K_RD, 0, 8'h00, 8'h00);
      add(K_DISP, 0, 8'h4F, 8'h42); add(K_WR, 0, 8'h38, 0);

      repeat (3) @(negedge Clk);
      chk("rst_busy_err_oe", {busy, err, lcd_data_oe}, 3'b000);
      chk("rst_data_out", lcd_data_out, 8'h00);
      chk("rst_flags", flags, 8'h12);
      chk("rst_shift", disp_shift, 6'd0);
      chk("rst_disp_char", disp_char, 8'h00);
      rst = 1'b0;
      @(negedge Clk);

      wr(0, 8'h38);
      chk("init_func", flags, 8'h1A);
      xfer(0, 0, 8'h01, q);
      wait_idle(n);
      chk("clear_busy_cycles", n, 160);
      wr(0, 8'h06);
      chk("init_entry", flags, 8'h1A);
      bad = 0;
      for (int i = 0; i < 128; i++) begin
         peek(7'(i), v);
         if (v !== 8'h20) bad++;
      end
      chk("blank_all_128", bad, 0);
      xfer(0, 1, 8'h00, q);
      chk("init_status", q, 8'h00);

      for (int i = 0; i < tbl.size(); i++) begin
         case (tbl[i].k)
            K_WR:   wr(tbl[i].rs, tbl[i].d);
            K_RD:   begin xfer(tbl[i].rs, 1'b1, tbl[i].d, q); wait_idle(n); chk($sformatf("vec%0d_read", i), q, tbl[i].exp); end
            K_DISP: begin peek(tbl[i].d[6:0], v); chk($sformatf("vec%0d_disp", i), v, tbl[i].exp); end
            K_FLG:  chk($sformatf("vec%0d_flags", i), flags, tbl[i].exp);
            K_SHF:  chk($sformatf("vec%0d_shift", i), {2'b00, disp_shift}, tbl[i].exp);
            default: ;
         endcase
      end

      xfer(0, 0, 8'h01, q);
      xfer(1, 0, 8'h41, q);
      chk("viol_err_pulse", err, 1'b1);
      @(negedge Clk);
      chk("viol_err_clear", err, 1'b0);
      xfer(0, 1, 8'h00, q);
      chk("viol_status_busy", q[7], 1'b1);
      chk("viol_oe_during_en", last_oe, 1'b1);
      chk("viol_oe_after_en", lcd_data_oe, 1'b0);
      wait_idle(n);
      xfer(0, 1, 8'h00, q);
      chk("viol_ac_unchanged", q, 8'h00);
      peek(7'd0, v);
      chk("viol_ddram0", v, 8'h20);

      for (int i = 0; i < 5; i++) begin
         wr(0, {1'b1, pa[i]});
         wr(1, pv[i]);
      end
      peek(7'd70, v);
      chk("prefill_70", v, 8'h41);
      xfer(0, 0, 8'h01, q);
      repeat (60) @(negedge Clk);
      rst = 1'b1;
      @(negedge Clk);
      chk("midclr_busy", busy, 1'b0);
      chk("midclr_disp_char", disp_char, 8'h00);
      chk("midclr_flags", flags, 8'h12);
      rst = 1'b0;
      xfer(0, 1, 8'h00, q);
      chk("midclr_status", q, 8'h00);
      for (int i = 0; i < 5; i++) begin
         peek(pa[i], v);
         chk($sformatf("midclr_ram%0d", pa[i]), v, (i < 2) ? 8'h20 : pv[i]);
      end

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule

// File: doc/lcd_hd44780_responder.md
Name: lcd_hd44780_responder

Overview:
- Synthesizable responder model of an HD44780-style character LCD: the panel side of the 8-bit E/RS/RW/DATA bus that the team's LCD host controllers drive.
- Decodes instructions, holds DDRAM (128x8) and CGRAM (64x8), and maintains the address counter (AC), busy flag and mode registers.
- Answers busy-flag and data reads on the bus.
- Used as the bench/emulation target for the LCD controllers. A second port lets a renderer or checker read DDRAM.

Parameters:
- BUSY_CYC, 40: Clk cycles busy stays high after any non-clear instruction or any data access.
- CLEAR_CYC, 160: minimum Clk cycles busy stays high after Clear Display. Must be >= 129.

Ports:
- Clk  in  1  system clock
- rst  in  1  synchronous, active-high reset
- LCD_EN  in  1  enable strobe from the host
- LCD_RS  in  1  0 = instruction/status, 1 = data
- LCD_RW  in  1  0 = write, 1 = read
- lcd_data_in  in  8  host-driven bus value
- lcd_data_out  out  8  value driven on reads
- lcd_data_oe  out  1  1 = responder drives the bus
- busy  out  1  busy flag
- err  out  1  one-cycle pulse on a protocol violation
- disp_on, cursor_on, blink_on  out  1 each  display-control bits D, C, B
- func_dl, func_n, func_f  out  1 each  function-set bits
- entry_id, entry_s  out  1 each  entry-mode bits
- disp_shift  out  6  display shift offset, mod 40
- disp_addr  in  7  DDRAM readback address
- disp_char  out  8  DDRAM[disp_addr], registered, latency 1

Behaviour:
- Bus sampling
  - LCD_EN/RS/RW/data are registered once (e_q, etc.).
  - Falling edge = e_q==1 and LCD_EN==0. The transfer uses the RS/RW/data values registered while e_q was 1.
- Reads
  - lcd_data_oe = e_q & rw_q.
  - RS=0: lcd_data_out = {busy, AC[6:0]}.
  - RS=1: lcd_data_out = (cg_mode ? CGRAM[AC[5:0]] : DDRAM[AC]).
  - A data read steps AC on the falling edge and starts a BUSY_CYC busy window.
- Write decode on falling edge (RW=0, RS=0), highest set bit wins:
  - 0x01 Clear: sweeps DDRAM to 0x20, AC=0, cg_mode=0, entry_id=1, disp_shift=0.
  - 0x02/0x03 Home: AC=0, cg_mode=0, disp_shift=0.
  - 0x04-07 Entry mode: entry_id=d[1], entry_s=d[0].
  - 0x08-0F Display control: D/C/B = d[2:0].
  - 0x10-1F Shift: d[3]=1 means display shift, disp_shift += d[2] ? +1 : -1 (mod 40); otherwise cursor step per d[2].
  - 0x20-3F Function set: dl=d[4], n=d[3], f=d[2].
  - 0x40-7F Set CGRAM address: AC=d[5:0], cg_mode=1.
  - 0x80-FF Set DDRAM address: AC=d[6:0], cg_mode=0.
- Data write (RS=1): writes the selected RAM at AC, then steps AC per entry_id. If entry_s=1 and DDRAM mode, disp_shift also moves by ±1.
- AC step rules
  - CGRAM mode: 6-bit wrap, 0x3F<->0x00.
  - DDRAM, func_n=1: inc 0x27->0x40, 0x67->0x00; dec 0x00->0x67, 0x40->0x27.
  - DDRAM, func_n=0: 0x00..0x4F with wrap both ways.
- FSM
  - IDLE: a transfer goes to EXEC with cnt=BUSY_CYC, or to CLEAR with ptr=0.
  - EXEC: busy=1, cnt decrements, returns to IDLE when cnt reaches 1.
  - CLEAR: writes DDRAM[ptr]=0x20 at 1 entry/cycle for all 128 entries, then EXEC with cnt=CLEAR_CYC-128.
  - Busy deasserts on the cycle the FSM returns to IDLE.
- Protocol violations (checked at falling edge)
  - Any instruction or data write while busy=1: ignored, err=1 for 1 cycle, no state change.
  - Data read while busy: returns the current RAM value, err=1, AC unchanged.
  - Status read (RS=0, RW=1) is always legal and never changes state.
- Simultaneous events: a disp_addr readback in the same cycle as a DDRAM write returns the old value. Host writes have priority over nothing; the sweep owns the write port only in CLEAR.
- Reset (synchronous, also mid-CLEAR/EXEC)
  - State returns to IDLE. AC=0, cg_mode=0.
  - busy=0, err=0, lcd_data_oe=0, lcd_data_out=0x00.
  - disp_on=cursor_on=blink_on=0; func_dl=1, func_n=0, func_f=0; entry_id=1, entry_s=0; disp_shift=0; disp_char=0x00.
  - RAM contents are not reset; a partial sweep stays partial.

Decomposition:
- Package lcd_pkg:
  - state encoding (IDLE, EXEC, CLEAR);
  - instruction opcode masks;
  - DDRAM line bounds 0x27/0x40/0x67/0x4F;
  - the 0x20 blank character.
- Sub-module lcd_ac_step (combinational): ac, inc/dec, cg_mode, func_n -> next AC. Shared by data access and cursor shift.

Test Plan:
- Init and clear: write 0x38, 0x01, 0x06 spaced by idle gaps.
  - func_dl=1, func_n=1, entry_id=1.
  - busy high exactly CLEAR_CYC cycles after the 0x01 edge.
  - All 128 disp_char reads = 0x20; status read returns 0x00.
- Data write: 0x80 then 0x4C, 0x43, 0x44 → disp_char at 0, 1, 2 = 0x4C, 0x43, 0x44; status read = 0x03.
- Line wrap: func_n=1, write 0xA7 then one data byte → DDRAM[0x27] written, AC=0x40. With entry_id=0 from AC=0x00, one data write → AC=0x67.
- CGRAM: 0x40 then 8 bytes 0x04,0x04,0x1F,0x04,0x04,0x00,0x1F,0x00 → AC=0x08. Then 0x7F plus two writes → AC wraps to 0x01. Then 0x40 and 8 RS=1/RW=1 reads return the pattern.
- Busy violation: send 0x01, then during CLEAR write data 0x41 → err pulses once, DDRAM unchanged. A status read in the window returns bit7=1 and lcd_data_oe is high only while LCD_EN is high.
- Reset mid-CLEAR: assert rst at ptr≈60 → next cycle busy=0, AC=0. Entries 60..127 keep their prior contents.
